// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared float width, in-flight tag type and id-width helper for the Sin arbiter
package cordic_pkg;

   localparam int FLOAT_W  = 32;
   localparam int TAG_ID_W = 4;   // wide enough for the largest supported requester count (16)

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

   function automatic int id_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cordic_rr_arbiter.sv
// rtl/cordic_rr_arbiter.sv - round-robin grant over N_REQ requesters, search starts after last_grant
module cordic_rr_arbiter
   import cordic_pkg::*;
#(
   parameter int  N_REQ = 4,
   localparam int ID_W  = id_width(N_REQ)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic             accept,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_id
);

   logic [ID_W-1:0] last_grant;
   logic [ID_W-1:0] idx;
   logic            found;

   // Combinational so a requester arriving on an idle cycle is granted in that same cycle.
   always_comb begin
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = ID_W'((int'(last_grant) + k) % N_REQ);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_id   = idx;
         end
      end
      if (reset) begin
         grant = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         last_grant <= ID_W'(N_REQ - 1);
      end else if (accept) begin
         last_grant <= grant_id;
      end
   end

endmodule

// File: rtl/cordic_sin_arbiter.sv
// rtl/cordic_sin_arbiter.sv - shares one pipelined Sin unit among N_REQ requesters, tags results back home
// Optional CORDIC_ARB_STATS_EN adds stat_issued / stat_stall counters.
module cordic_sin_arbiter
   import cordic_pkg::*;
#(
   parameter int  N_REQ       = 4,
   parameter int  SIN_LATENCY = 16,
   localparam int ID_W        = id_width(N_REQ)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic [FLOAT_W*N_REQ-1:0] req_angle,
   output logic [FLOAT_W-1:0]       sin_in,
   input  logic [FLOAT_W-1:0]       sin_out,
   output logic [N_REQ-1:0]         resp_valid,
   output logic [FLOAT_W-1:0]       resp_data,
   output logic [ID_W-1:0]          resp_id
`ifdef CORDIC_ARB_STATS_EN
   ,
   output logic [31:0]              stat_issued,
   output logic [31:0]              stat_stall
`endif
);

   logic [N_REQ-1:0]   grant;
   logic [ID_W-1:0]    grant_id;
   logic               accept;
   logic [FLOAT_W-1:0] sel_angle;
   tag_t               tag_line [0:SIN_LATENCY];
   tag_t               tail;

   cordic_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .clock    (clock),
      .reset    (reset),
      .req      (req_valid),
      .accept   (accept),
      .grant    (grant),
      .grant_id (grant_id)
   );

   assign req_ready = grant;
   assign accept    = |(req_valid & grant);

   always_comb begin
      sel_angle = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_angle = req_angle[FLOAT_W*i +: FLOAT_W];
         end
      end
   end

   // Stage 0 keeps the last accepted id when idle, so resp_id holds between results.
   always_ff @(posedge clock) begin
      if (reset) begin
         sin_in <= '0;
         for (int s = 0; s <= SIN_LATENCY; s++) begin
            tag_line[s] <= '0;
         end
      end else begin
         if (accept) begin
            sin_in         <= sel_angle;
            tag_line[0].id <= TAG_ID_W'(grant_id);
         end
         tag_line[0].valid <= accept;
         for (int s = 1; s <= SIN_LATENCY; s++) begin
            tag_line[s] <= tag_line[s-1];
         end
      end
   end

   assign tail      = tag_line[SIN_LATENCY];
   assign resp_id   = tail.id[ID_W-1:0];
   assign resp_data = sin_out;

   always_comb begin
      resp_valid = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (tail.valid && (tail.id == TAG_ID_W'(i))) begin
            resp_valid[i] = 1'b1;
         end
      end
   end

`ifdef CORDIC_ARB_STATS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         stat_issued <= '0;
         stat_stall  <= '0;
      end else begin
         if (accept) begin
            stat_issued <= stat_issued + 32'd1;
         end
         if (|(req_valid & ~grant)) begin
            stat_stall <= stat_stall + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cordic_sin_arbiter.sv
// tb/tb_cordic_sin_arbiter.sv - table-driven scoreboard bench for cordic_sin_arbiter with a behavioural Sin pipeline
module tb_cordic_sin_arbiter;

   localparam int N_REQ = 4;
   localparam int LAT   = 16;

   typedef struct {
      logic             rst;
      logic [3:0]       valid;
      logic [3:0][31:0] ang;
      logic [3:0]       exp_ready;
      real              exp_sin;
   } vec_t;

   typedef struct {
      int  id;
      real s;
      int  due;
   } exp_t;

   logic              clock = 1'b0;
   logic              reset;
   logic [3:0]        req_valid;
   logic [3:0]        req_ready;
   logic [127:0]      req_angle;
   logic [31:0]       sin_in;
   logic [31:0]       sin_out;
   logic [3:0]        resp_valid;
   logic [31:0]       resp_data;
   logic [1:0]        resp_id;
`ifdef CORDIC_ARB_STATS_EN
   logic [31:0]       stat_issued;
   logic [31:0]       stat_stall;
`endif

   int   n_checks  = 0;
   int   n_fail    = 0;
   int   resp_seen = 0;
   int   cyc       = 0;
   logic [31:0] exp_sin_in = 32'd0;
   exp_t sb[$];
   vec_t vecs[$];

   always #5 clock = ~clock;

   cordic_sin_arbiter #(.N_REQ(N_REQ), .SIN_LATENCY(LAT)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_angle  (req_angle),
      .sin_in     (sin_in),
      .sin_out    (sin_out),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_id    (resp_id)
`ifdef CORDIC_ARB_STATS_EN
      ,
      .stat_issued(stat_issued),
      .stat_stall (stat_stall)
`endif
   );

   function automatic real f32_to_real(input logic [31:0] b);
      logic [63:0] d;
      if (b[30:23] == 8'd0) return 0.0;
      d = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] real_to_f32(input real r);
      logic [63:0] d;
      int          e;
      d = $realtobits(r);
      e = int'(d[62:52]) - 1023 + 127;
      if (d[62:52] == 11'd0 || e <= 0) return 32'd0;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   // Behavioural Sin unit: fixed LAT-cycle pipeline, no handshake.
   logic [31:0] pipe [LAT];
   always @(posedge clock) begin
      pipe[0] <= real_to_f32($sin(f32_to_real(sin_in)));
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign sin_out = pipe[LAT-1];

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_real(input string name, input logic [31:0] act, input real exp);
      real a;
      a = f32_to_real(act);
      n_checks++;
      if ((a - exp > 1e-5) || (exp - a > 1e-5)) begin
         n_fail++;
         $display("FAIL %s: got %f expected %f (cycle %0d)", name, a, exp, cyc);
      end
   endtask

   // Response side of the scoreboard.
   always @(negedge clock) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].due < cyc) begin
         e = sb.pop_front();
         check(1'b0, "resp_missing", 32'(cyc), 32'(e.due));
      end
      if (resp_valid != 4'b0) begin
         resp_seen++;
         if (sb.size() == 0) begin
            check(1'b0, "resp_unexpected", 32'(resp_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            check(resp_valid == (4'b0001 << e.id), "resp_valid", 32'(resp_valid), 32'(4'b0001 << e.id));
            check(resp_id == 2'(e.id), "resp_id", 32'(resp_id), 32'(e.id));
            check(cyc == e.due, "resp_latency", 32'(cyc), 32'(e.due));
            check_real("resp_data", resp_data, e.s);
         end
      end
   end

   function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0][31:0] a,
                               input logic [3:0] er, input real s);
      vec_t x;
      x.rst = r; x.valid = v; x.ang = a; x.exp_ready = er; x.exp_sin = s;
      return x;
   endfunction

   task automatic apply(input vec_t v);
      exp_t e;
      @(negedge clock);
      reset     = v.rst;
      req_valid = v.valid;
      req_angle = v.ang;
      if (v.rst) sb.delete();
      #1;
      check(req_ready == v.exp_ready, "req_ready", 32'(req_ready), 32'(v.exp_ready));
      for (int i = 0; i < N_REQ; i++) begin
         if (v.exp_ready[2'(i)]) begin
            e.id = i; e.s = v.exp_sin; e.due = cyc + 1 + LAT;
            sb.push_back(e);
            exp_sin_in = v.ang[2'(i)];
         end
      end
      if (v.rst) exp_sin_in = 32'd0;
      @(posedge clock);
      #1;
      check(sin_in == exp_sin_in, "sin_in", sin_in, exp_sin_in);
   endtask

   logic [3:0][31:0] A    = {32'h3ffb53d8, 32'h40fb53ce, 32'h407b53d8, 32'h00000000};
   logic [3:0][31:0] ASP  = {32'h00000000, 32'h00000000, 32'h00000000, 32'h3ffb53d8};
   logic [3:0][31:0] ASG  = {32'h00000000, 32'h3ffb53d8, 32'h00000000, 32'h00000000};
   real              S[4] = '{0.0, -0.707108, 1.0, 0.923879};
   logic [3:0]       none = 4'b0000;

   initial begin
      int snap;

      // Fairness from reset, then sparse wrap (1 then 0), then a lone request from requester 2.
      for (int c = 0; c < 40; c++) vecs.push_back(mk(1'b0, 4'hF, A, 4'(1 << (c % 4)), S[c % 4]));
      vecs.push_back(mk(1'b0, 4'b0010, ASP, 4'b0010, 0.0));
      vecs.push_back(mk(1'b0, 4'b0001, ASP, 4'b0001, 0.923879));
      vecs.push_back(mk(1'b0, 4'b0100, ASG, 4'b0100, 0.923879));
      for (int c = 0; c < 20; c++) vecs.push_back(mk(1'b0, none, ASG, none, 0.0));

      reset     = 1'b1;
      req_valid = 4'hF;
      req_angle = A;
      repeat (2) begin
         @(posedge clock);
         #1;
         check(req_ready == 4'b0, "reset_ready", 32'(req_ready), 32'd0);
         check(resp_valid == 4'b0, "reset_resp_valid", 32'(resp_valid), 32'd0);
         check(sin_in == 32'd0, "reset_sin_in", sin_in, 32'd0);
      end
      check(resp_id == 2'd0, "reset_resp_id", 32'(resp_id), 32'd0);
`ifdef CORDIC_ARB_STATS_EN
      check(stat_issued == 32'd0, "reset_stat_issued", stat_issued, 32'd0);
      check(stat_stall == 32'd0, "reset_stat_stall", stat_stall, 32'd0);
`endif
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i]);
`ifdef CORDIC_ARB_STATS_EN
         if (i == 39) begin
            check(stat_issued == 32'd40, "stat_issued_40", stat_issued, 32'd40);
            check(stat_stall == 32'd40, "stat_stall_40", stat_stall, 32'd40);
         end
`endif
      end
      check(resp_id == 2'd2, "resp_id_hold", 32'(resp_id), 32'd2);
      check(resp_valid == 4'b0, "idle_resp_valid", 32'(resp_valid), 32'd0);

      // Mid-flight reset: five accepts, reset at the third accept + 8, nothing may come back.
      snap = resp_seen;
      apply(mk(1'b0, 4'b1000, A, 4'b1000, S[3]));
      apply(mk(1'b0, 4'b0001, A, 4'b0001, S[0]));
      apply(mk(1'b0, 4'b0010, A, 4'b0010, S[1]));
      apply(mk(1'b0, 4'b0100, A, 4'b0100, S[2]));
      apply(mk(1'b0, 4'b1000, A, 4'b1000, S[3]));
      repeat (5) apply(mk(1'b0, none, A, none, 0.0));
      apply(mk(1'b1, none, A, none, 0.0));
      check(resp_id == 2'd0, "midreset_resp_id", 32'(resp_id), 32'd0);
      repeat (30) apply(mk(1'b0, none, A, none, 0.0));
      check(resp_seen == snap, "dropped_results", 32'(resp_seen), 32'(snap));

      // After reset last_grant is 3, so requester 1 wins directly.
      apply(mk(1'b0, 4'b0010, A, 4'b0010, S[1]));
      repeat (20) apply(mk(1'b0, none, A, none, 0.0));
`ifdef CORDIC_ARB_STATS_EN
      check(stat_issued == 32'd1, "stat_issued_post_reset", stat_issued, 32'd1);
      check(stat_stall == 32'd0, "stat_stall_post_reset", stat_stall, 32'd0);
`endif
      check(sb.size() == 0, "scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cordic_sin_arbiter.md
# cordic_sin_arbiter

Round-robin front end that shares one fully pipelined `Sin` CORDIC unit (IEEE-754 single-precision angle in, sine out, one new operand per clock, fixed latency, no valid/ready) between `N_REQ` requesters. The block accepts angles over a valid/ready handshake and registers the winning angle into the unit. It carries a requester tag down a delay line matched to the unit latency, and returns each result to its originator with a one-cycle valid strobe. It sits between the angle-producing clients and the `Sin` instance.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `SIN_LATENCY`, 16: cycles from the `Sin` unit's `io_in` to `io_out`. Must equal the instantiated unit's latency.
- `clock` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in N_REQ: per-requester angle valid.
- `req_ready` out N_REQ: per-requester accept, one-hot or zero.
- `req_angle` in 32*N_REQ: flattened float32 angles, requester i at bits [32i+31:32i].
- `sin_in` out 32: drives the `Sin` unit's `io_in`.
- `sin_out` in 32: from the `Sin` unit's `io_out`.
- `resp_valid` out N_REQ: one-hot result strobe.
- `resp_data` out 32: float32 sine, broadcast to all requesters.
- `resp_id` out clog2(N_REQ): index of the requester owning `resp_data`.

## Operation
- Grant: search starts at `last_grant+1` and wraps modulo N_REQ; the first asserted `req_valid` wins. `req_ready` is combinational from `req_valid` and `last_grant`, so an idle cycle costs nothing.
- Accept occurs when `req_valid[i] & req_ready[i]`. On an accept edge:
  - `sin_in` is loaded with that requester's angle.
  - `last_grant` is set to i.
  - Tag stage 0 is loaded with {valid=1, id=i}.
- With no accept:
  - Tag stage 0 is loaded with valid=0.
  - `sin_in` holds its previous value; no toggling.
  - `last_grant` is unchanged.
- Tag line: SIN_LATENCY further registers of {valid, id}, shifting every cycle. There is no stall: the unit cannot stall, and responses have no backpressure. Requesters must always sink results.
- Output:
  - `resp_valid[id] = tail.valid`.
  - `resp_id = tail.id`.
  - `resp_data = sin_out`, combinational pass-through.
  - When `tail.valid=0`, `resp_id` holds its last value and `resp_data` is don't-care.
- Order: results return in acceptance order. Throughput is one per cycle aggregate. With all requesters valid, each is served once per N_REQ cycles.
- `req_angle` is not interpreted: NaN, Inf and denormal values pass through to the unit unchanged.

## Timing
- Reset values:
  - `sin_in` = 0.
  - All tag stages valid=0, id=0.
  - `last_grant` = N_REQ-1, so requester 0 wins first.
  - `resp_valid` = 0, `resp_id` = 0.
  - `req_ready` follows its combinational rule. It is forced to 0 while `reset` is high, so nothing is accepted in a reset cycle.
- Latency: request accepted at edge k → `sin_in` valid after edge k → `resp_valid` high for exactly the cycle after edge k+SIN_LATENCY.
- Back-to-back accepts on consecutive edges give responses on consecutive cycles.
- Reset mid-operation clears the tag line and drops in-flight results. No `resp_valid` is asserted until a post-reset request completes, even though `sin_out` keeps changing.
- Simultaneous events:
  - An accept and a response for the same requester in the same cycle are independent and both happen.
  - A requester may re-request in the cycle after its own grant, but it only wins again once all other valid requesters have been served.

## Configuration
- `CORDIC_ARB_STATS_EN` defined: adds two output ports, both cleared on reset and wrapping at 2^32:
  - `stat_issued` (32): counts accepts.
  - `stat_stall` (32): counts cycles where any `req_valid` is high but that requester is not granted, counted once per cycle.
- Not defined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `cordic_pkg`:
  - `FLOAT_W=32`.
  - Tag struct typedef {valid, id}.
  - Helper for the id width, clog2(N_REQ) with minimum 1.
- Sub-module `cordic_rr_arbiter`:
  - Parameter N_REQ.
  - Inputs `clock`, `reset`, `req`, `accept`.
  - Outputs one-hot `grant`, `grant_id`.
  - Owns `last_grant`.
- The top level holds the angle mux, the `sin_in` register, the tag line and the stats counters.

## Test plan
All scenarios use a behavioural `Sin` model with SIN_LATENCY=16 and N_REQ=4.
- Reset check: hold `reset` 2 cycles with all `req_valid` high → no `req_ready`, `resp_valid`=0, `sin_in`=0; first post-reset grant goes to requester 0.
- Single request: requester 2 sends 0x3ffb53d8 (1.963496) → `req_ready[2]` high one cycle; `resp_valid`=4'b0100 and `resp_id`=2 exactly 16 cycles after accept; `resp_data` is within 1e-5 of 0.923879.
- Fairness: all four valid continuously for 40 cycles, angles 0x00000000, 0x407b53d8, 0x40fb53ce, 0x3ffb53d8 → grants 0,1,2,3,0,… with no gaps; responses in the same order; sin values 0.0, -0.707108, 1.0, 0.923879.
- Sparse/wrap: `last_grant`=3; only requester 1 valid, then only requester 0 → grants 1 then 0, with no idle cycles inserted.
- Mid-flight reset: issue 5 requests, assert `reset` 1 cycle at request 3's accept+8 → no `resp_valid` ever appears for any of the 5; a new request completes normally 16 cycles after its accept.
- Stats (`CORDIC_ARB_STATS_EN`): 40-cycle fairness run → `stat_issued`=40, `stat_stall`=40 (someone is always waiting); both reset to 0.
